// File: rtl/divisor_secuencial_pkg.sv
// rtl/divisor_secuencial_pkg.sv - shared ALU constants for the sequential divider
// Purpose: FSM state encoding, default operand widths shared with the Booth
//          multiplier, and the step-counter width helper.
// Ports:   none (package).
package divisor_secuencial_pkg;

  // Default widths, common with the multiplier (its product width is NW).
  localparam int NW_DEF = 16;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // The step counter must hold the value NW itself.
  function automatic int cnt_width(input int nw);
    return $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/divisor_secuencial_abs_neg.sv
// rtl/divisor_secuencial_abs_neg.sv - conditional two's-complement negate
// Purpose: y = neg ? -a : a, width W. Used for operand magnitudes and result sign fix.
// Ports:   a   in  W  operand
//          neg in  1  negate when high
//          y   out W  result
module abs_neg #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? ((~a) + {{(W-1){1'b0}}, 1'b1}) : a;

endmodule

// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - sequential signed restoring divider (NW / DW bits)
// Purpose: q = A / B truncated toward zero, r = A % B (sign of A), one quotient
//          bit per clock, with divide-by-zero and overflow status.
// Ports:   clk   in  1   clock, rising edge
//          rst   in  1   synchronous active-high reset
//          start in  1   request, sampled only in IDLE
//          A     in  NW  signed dividend
//          B     in  DW  signed divisor
//          q     out NW  signed quotient
//          r     out DW  signed remainder
//          busy  out 1   division in progress
//          done  out 1   one-cycle result pulse
//          dz    out 1   divide-by-zero flag
//          ovf   out 1   quotient overflow flag
module divisor_secuencial
  import divisor_secuencial_pkg::*;
#(
  parameter int NW = NW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] A,
  input  logic [DW-1:0] B,
  output logic [NW-1:0] q,
  output logic [DW-1:0] r,
  output logic          busy,
  output logic          done,
  output logic          dz,
  output logic          ovf
);

  localparam int CW = cnt_width(NW);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW:0]   quo_q, quo_d;
  logic [DW:0]   rem_q, rem_d;
  logic [DW:0]   div_q, div_d;
  logic          sgn_quo_q, sgn_quo_d;
  logic          sgn_rem_q, sgn_rem_d;
  logic          ovf_pend_q, ovf_pend_d;
  logic [NW-1:0] q_q, q_d;
  logic [DW-1:0] r_q, r_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic [NW:0]   a_mag;
  logic [DW:0]   b_mag;
  logic [NW-1:0] q_fix;
  logic [DW-1:0] r_fix;
  logic [DW:0]   rem_sh;
  logic [DW:0]   trial;
  logic          unused_bits;

  // Magnitudes are one bit wider so -2^(NW-1) and -2^(DW-1) stay exact.
  abs_neg #(.W(NW + 1)) u_abs_a (.a({A[NW-1], A}), .neg(A[NW-1]), .y(a_mag));
  abs_neg #(.W(DW + 1)) u_abs_b (.a({B[DW-1], B}), .neg(B[DW-1]), .y(b_mag));

  // Quotient magnitude is at most 2^(NW-1), so its low NW bits are enough;
  // the -32768 / -1 case wraps back to -32768 here. Remainder magnitude < 2^(DW-1).
  abs_neg #(.W(NW)) u_fix_q (.a(quo_q[NW-1:0]), .neg(sgn_quo_q), .y(q_fix));
  abs_neg #(.W(DW)) u_fix_r (.a(rem_q[DW-1:0]), .neg(sgn_rem_q), .y(r_fix));

  // Restoring step: shift the next dividend bit into the partial remainder
  // and try subtracting |B|; the sign of trial decides the quotient bit.
  assign rem_sh = {rem_q[DW-1:0], quo_q[NW-1]};
  assign trial  = rem_sh - div_q;

  // Top bits never carry information after the step (remainder < |B|).
  assign unused_bits = rem_q[DW] ^ quo_q[NW];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    div_d      = div_q;
    sgn_quo_d  = sgn_quo_q;
    sgn_rem_d  = sgn_rem_q;
    ovf_pend_d = ovf_pend_q;
    q_d        = q_q;
    r_d        = r_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    dz_d       = dz_q;
    ovf_d      = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (B == '0) begin
            q_d    = '0;
            r_d    = '0;
            dz_d   = 1'b1;
            ovf_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            sgn_quo_d  = A[NW-1] ^ B[DW-1];
            sgn_rem_d  = A[NW-1];
            ovf_pend_d = (A == {1'b1, {(NW-1){1'b0}}}) && (B == {DW{1'b1}});
            quo_d      = a_mag;
            div_d      = b_mag;
            rem_d      = '0;
            cnt_d      = CW'(NW);
            busy_d     = 1'b1;
            state_d    = ST_CALC;
          end
        end
      end

      ST_CALC: begin
        rem_d = trial[DW] ? rem_sh : trial;
        quo_d = {quo_q[NW-1:0], ~trial[DW]};
        cnt_d = cnt_q - CW'(1);
        // Last of the NW steps: busy drops as the sign-fix cycle starts.
        if (cnt_q == CW'(1)) begin
          state_d = ST_FIX;
          busy_d  = 1'b0;
        end
      end

      ST_FIX: begin
        q_d     = q_fix;
        r_d     = r_fix;
        dz_d    = 1'b0;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      sgn_quo_q  <= 1'b0;
      sgn_rem_q  <= 1'b0;
      ovf_pend_q <= 1'b0;
      q_q        <= '0;
      r_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      sgn_quo_q  <= sgn_quo_d;
      sgn_rem_q  <= sgn_rem_d;
      ovf_pend_q <= ovf_pend_d;
      q_q        <= q_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
      ovf_q      <= ovf_d;
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb/tb_divisor_secuencial.sv - self-checking bench for divisor_secuencial
module tb_divisor_secuencial;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [15:0] a_in;
  logic signed [7:0]  b_in;
  logic [15:0]        q;
  logic [7:0]         r;
  logic               busy;
  logic               done;
  logic               dz;
  logic               ovf;

  int checks;
  int errors;

  divisor_secuencial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (a_in),
    .B     (b_in),
    .q     (q),
    .r     (r),
    .busy  (busy),
    .done  (done),
    .dz    (dz),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division (SV truncates toward zero, % follows dividend).
  function automatic void ref_div(input logic signed [15:0] a, input logic signed [7:0] b,
                                  output logic [15:0] eq, output logic [7:0] er,
                                  output logic edz, output logic eovf);
    int ai, bi, qi, ri;
    ai = a;
    bi = b;
    if (bi == 0) begin
      eq = 16'd0; er = 8'd0; edz = 1'b1; eovf = 1'b0;
    end else begin
      qi   = ai / bi;
      ri   = ai % bi;
      eq   = qi[15:0];
      er   = ri[7:0];
      edz  = 1'b0;
      eovf = (ai == -32768) && (bi == -1);
    end
  endfunction

  // Pulse start with the operands, scramble the inputs afterwards, and wait
  // (bounded) for done. lat counts edges after the start-sampling edge.
  task automatic run_div(input logic signed [15:0] a, input logic signed [7:0] b,
                         output int lat, output int busy_cnt);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    lat = -1;
    busy_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    a_in  = 16'($urandom);
    b_in  = 8'($urandom);
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      if (busy) busy_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({q, r, busy, done, dz, ovf} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs got q=%0h r=%0h busy=%b done=%b dz=%b ovf=%b exp all 0",
               q, r, busy, done, dz, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [15:0] eq; logic [7:0] er; logic edz, eovf;
    ref_div(16'sd100, 8'sd7, eq, er, edz, eovf);
    run_div(16'sd100, 8'sd7, lat, bc);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL basic_latency got %0d exp 17", lat); end
    checks++;
    if (bc !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 16", bc); end
    checks++;
    if ({q, r, dz, ovf} !== {eq, er, edz, eovf}) begin
      errors++;
      $display("FAIL basic_result got q=%0d r=%0d dz=%b ovf=%b exp q=%0d r=%0d dz=%b ovf=%b",
               $signed(q), $signed(r), dz, ovf, $signed(eq), $signed(er), edz, eovf);
    end
    @(posedge clk); #1;
    checks++;
    if ({done, q, r} !== {1'b0, eq, er}) begin
      errors++;
      $display("FAIL basic_hold got done=%b q=%0d r=%0d exp done=0 q=%0d r=%0d",
               done, $signed(q), $signed(r), $signed(eq), $signed(er));
    end
  endtask

  // Sign matrix, multiplier round trip and the -2^15 corner cases.
  task automatic test_directed;
    logic signed [15:0] av [8] = '{-16'sd100, 16'sd100, -16'sd100, -16'sd27, -16'sd8,
                                   -16'sd32768, -16'sd32768, 16'sd8};
    logic signed [7:0]  bv [8] = '{8'sd7, -8'sd7, -8'sd7, -8'sd3, 8'sd2, -8'sd1, -8'sd128, 8'sd0};
    logic [15:0] xq [8] = '{-16'sd14, -16'sd14, 16'sd14, 16'sd9, -16'sd4, -16'sd32768, 16'sd256, 16'sd0};
    logic [7:0]  xr [8] = '{-8'sd2, 8'sd2, -8'sd2, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0};
    logic        xo [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        xz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int lat, bc;
    for (int i = 0; i < 8; i++) begin
      run_div(av[i], bv[i], lat, bc);
      checks++;
      if ({q, r, dz, ovf} !== {xq[i], xr[i], xz[i], xo[i]}) begin
        errors++;
        $display("FAIL directed_%0d got q=%0d r=%0d dz=%b ovf=%b exp q=%0d r=%0d dz=%b ovf=%b",
                 i, $signed(q), $signed(r), dz, ovf, $signed(xq[i]), $signed(xr[i]), xz[i], xo[i]);
      end
      checks++;
      if (lat !== (xz[i] ? 0 : 17) || bc !== (xz[i] ? 0 : 16)) begin
        errors++;
        $display("FAIL directed_timing_%0d got lat=%0d busy=%0d exp lat=%0d busy=%0d",
                 i, lat, bc, xz[i] ? 0 : 17, xz[i] ? 0 : 16);
      end
    end
  endtask

  // Back-to-back: every start lands in the done cycle of the previous result.
  task automatic test_random;
    logic signed [15:0] a;
    logic signed [7:0]  b;
    logic [15:0] eq; logic [7:0] er; logic edz, eovf;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 8'($urandom);
      if (i % 8 == 3) b = 8'sd0;
      if (i % 8 == 4) b = 8'sd0;
      if (i % 10 == 6) a = -16'sd32768;
      ref_div(a, b, eq, er, edz, eovf);
      run_div(a, b, lat, bc);
      checks++;
      if ({q, r, dz, ovf} !== {eq, er, edz, eovf} || lat !== (edz ? 0 : 17)) begin
        errors++;
        $display("FAIL random_%0d a=%0d b=%0d got q=%0d r=%0d dz=%b ovf=%b lat=%0d exp q=%0d r=%0d dz=%b ovf=%b lat=%0d",
                 i, a, b, $signed(q), $signed(r), dz, ovf, lat,
                 $signed(eq), $signed(er), edz, eovf, edz ? 0 : 17);
      end
    end
  endtask

  // Two divide-by-zero requests in a row give done in consecutive cycles.
  task automatic test_back_to_back_dz;
    int lat1, lat2, bc;
    int lat_prev;
    run_div(16'sd8, 8'sd0, lat1, bc);
    lat_prev = lat1;
    run_div(-16'sd5, 8'sd0, lat2, bc);
    checks++;
    if (lat_prev !== 0 || lat2 !== 0 || dz !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_back_to_back got lat=%0d,%0d dz=%b busy=%b exp lat=0,0 dz=1 busy=0",
               lat_prev, lat2, dz, busy);
    end
  endtask

  task automatic test_protocol;
    int lat;
    int done_seen;
    int bc;
    // Second start at clock 5 must be ignored.
    a_in = 16'sd50; b_in = 8'sd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        a_in = 16'sd1; b_in = 8'sd1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 17 || q !== 16'd10 || r !== 8'd0) begin
      errors++;
      $display("FAIL ignore_start got lat=%0d q=%0d r=%0d exp lat=17 q=10 r=0",
               lat, $signed(q), $signed(r));
    end

    // Reset at clock 8 of a division aborts it.
    a_in = 16'sd1234; b_in = -8'sd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({q, r, busy, done, dz, ovf} !== 28'd0) begin
      errors++;
      $display("FAIL mid_reset got q=%0h r=%0h busy=%b done=%b dz=%b ovf=%b exp all 0",
               q, r, busy, done, dz, ovf);
    end
    rst = 1'b0;
    done_seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("FAIL aborted_report got %0d active cycles exp 0", done_seen);
    end

    run_div(16'sd1000, -8'sd9, lat, bc);
    checks++;
    if (lat !== 17 || q !== -16'sd111 || r !== 8'sd1 || dz !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL after_reset got lat=%0d q=%0d r=%0d dz=%b ovf=%b exp lat=17 q=-111 r=1 dz=0 ovf=0",
               lat, $signed(q), $signed(r), dz, ovf);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_directed();
    test_random();
    test_back_to_back_dz();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
